// File: rtl/vending_ctrl.sv
// vending_ctrl: command FSM for the vending machine datapath.
// Synchronizes the coin sensor and issues load/clear commands to the total register.
// Raises the dispense pulse once the total reaches the price.
// Pays change as unit-coin pulses with an idle gap between them.
// Optional feature: define VENDING_CTRL_TIMEOUT_EN for an inactivity refund path.
module vending_ctrl #(
    parameter int COIN_UNIT      = 25,
    parameter int PULSE_GAP      = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       c,
    input  logic       tot_lt_s,
    input  logic [7:0] tot,
    input  logic [7:0] s,
    output logic       tot_ld,
    output logic       tot_clr,
    output logic       d,
    output logic       chg_p,
    output logic       busy
);

    localparam int         GAP_W = $clog2(PULSE_GAP + 1);
    localparam logic [7:0] COIN8 = 8'(COIN_UNIT);

`ifdef VENDING_CTRL_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_INIT, S_WAIT, S_ADD, S_DISP, S_CHANGE, S_REFUND
    } state_e;
`else
    typedef enum logic [2:0] {
        S_INIT, S_WAIT, S_ADD, S_DISP, S_CHANGE
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [2:0]         sync_q, sync_d;       // [1:0] synchronizer, [2] edge-detect history
    logic               coin_ev_q, coin_ev_d;
    logic [7:0]         chg_cnt_q, chg_cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         diff;
`ifdef VENDING_CTRL_TIMEOUT_EN
    logic [15:0]        idle_q, idle_d;
`endif

    // Coin input: two-flop synchronizer, then registered rising-edge pulse.
    always_comb begin
        sync_d    = {sync_q[1:0], c};
        coin_ev_d = sync_q[1] & ~sync_q[2];
    end

    // Next-state and Moore output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        chg_cnt_d = chg_cnt_q;
        gap_d     = gap_q;
        tot_ld    = 1'b0;
        tot_clr   = 1'b0;
        d         = 1'b0;
        chg_p     = 1'b0;
        busy      = 1'b0;
        diff      = tot - s;
`ifdef VENDING_CTRL_TIMEOUT_EN
        idle_d    = '0;
`endif
        case (state_q)
            S_INIT: begin
                tot_clr = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (coin_ev_q) begin
                    state_d = S_ADD;
                end else if (!tot_lt_s) begin
                    state_d = S_DISP;
`ifdef VENDING_CTRL_TIMEOUT_EN
                end else if (tot != 8'd0) begin
                    if (idle_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_REFUND;
                    end else begin
                        idle_d = idle_q + 16'd1;
                    end
`endif
                end
            end
            S_ADD: begin
                tot_ld  = 1'b1;
                state_d = S_WAIT;
            end
            S_DISP: begin
                d         = 1'b1;
                busy      = 1'b1;
                chg_cnt_d = diff / COIN8;
                gap_d     = '0;
                state_d   = S_CHANGE;
            end
            S_CHANGE: begin
                busy = 1'b1;
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (chg_cnt_q == 8'd0) begin
                    state_d = S_INIT;
                end else begin
                    chg_p     = 1'b1;
                    chg_cnt_d = chg_cnt_q - 8'd1;
                    gap_d     = GAP_W'(PULSE_GAP);
                end
            end
`ifdef VENDING_CTRL_TIMEOUT_EN
            S_REFUND: begin
                busy      = 1'b1;
                chg_cnt_d = tot / COIN8;
                gap_d     = '0;
                state_d   = S_CHANGE;
            end
`endif
            default: state_d = S_INIT;
        endcase
    end

    // State and counter registers; reset aborts any payout in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q   <= S_INIT;
            sync_q    <= '0;
            coin_ev_q <= 1'b0;
            chg_cnt_q <= '0;
            gap_q     <= '0;
`ifdef VENDING_CTRL_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            coin_ev_q <= coin_ev_d;
            chg_cnt_q <= chg_cnt_d;
            gap_q     <= gap_d;
`ifdef VENDING_CTRL_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
- Control FSM for the vending machine; the command side of the existing total/compare datapath.
- Detects coin insertions and drives the datapath's tot_ld/tot_clr. Reads tot_lt_s back from the datapath.
- Issues the dispense pulse and pays out change as unit-coin pulses.
- Sits between the coin-sensor/payout pins and the datapath in the top level.

Parameters:
- COIN_UNIT, 25, value of one change coin; change is paid as floor((tot-s)/COIN_UNIT) pulses.
- PULSE_GAP, 4, idle cycles between consecutive chg_p pulses (minimum 1).
- TIMEOUT_CYCLES, 1000, inactivity limit for the refund feature (used only with the macro).

Ports:
- clk_i  input  1  system clock, all state on rising edge
- rst_i  input  1  asynchronous, active-high reset
- c  input  1  raw coin-detect level from sensor; asynchronous to clk_i
- tot_lt_s  input  1  from datapath: running total < price
- tot  input  8  from datapath: running total (unsigned)
- s  input  8  price (unsigned), stable while not in INIT
- tot_ld  output  1  to datapath: load tot+a this cycle
- tot_clr  output  1  to datapath: synchronous clear of total
- d  output  1  dispense, one-cycle pulse
- chg_p  output  1  change-coin pulse, one cycle per unit
- busy  output  1  high in DISP/CHANGE; coin slot must be blocked

Behaviour:
- Reset (async): state=INIT, sync flops=0, gap/change counters=0. Outputs d, chg_p, tot_ld = 0, busy=0, tot_clr=1 (Moore output of INIT).
- Coin input: 2-flop synchronizer on c, then rising-edge detect. coin_ev is a one-cycle pulse, 3 cycles after c rises. A level held high counts once.
- States and Moore outputs:
  - INIT: tot_clr=1; -> WAIT next cycle.
  - WAIT: all outputs 0.
    - coin_ev -> ADD.
    - else !tot_lt_s -> DISP.
    - coin_ev has priority over !tot_lt_s in the same cycle.
  - ADD: tot_ld=1 for exactly one cycle; -> WAIT. tot_lt_s is evaluated only in WAIT, i.e. after the datapath register has updated.
  - DISP: d=1, busy=1. Latch chg_cnt = (tot - s) / COIN_UNIT. Subtraction is 8-bit unsigned; tot>=s is guaranteed here. -> CHANGE.
  - CHANGE: busy=1.
    - chg_cnt==0 -> INIT.
    - Otherwise assert chg_p for 1 cycle, decrement chg_cnt, then wait PULSE_GAP cycles before the next pulse.
    - After the last pulse, wait the gap, then -> INIT.
- Coin events in DISP/CHANGE/INIT are discarded (not queued).
- Latency: coin edge on c to tot_ld = 4 cycles. Total reaching price to d = 1 cycle after the ADD cycle's update (WAIT cycle), d asserted the following cycle.
- Price 0: first WAIT cycle sees !tot_lt_s and dispenses with no coin. Change 0.
- Total saturation/overflow is the datapath's concern; this block makes no assumption beyond 8-bit unsigned.
- Reset mid-CHANGE aborts payout immediately. Unpaid change is lost by design.

Optional Feature:
- Macro: VENDING_CTRL_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter runs in WAIT while tot != 0; it resets on coin_ev and on leaving WAIT.
  - Reaching TIMEOUT_CYCLES -> REFUND state (busy=1, d never asserted).
  - REFUND latches chg_cnt = tot / COIN_UNIT and enters CHANGE; payout then proceeds as normal.
- Not defined: no counter, no REFUND state; WAIT waits indefinitely.

Test Plan:
- Reset held, then released -> tot_clr=1, d=0, chg_p=0, busy=0 during reset. First cycle after release is INIT; WAIT follows.
- s=200, coins a=50,50,100 (c pulsed, 20 cycles apart, datapath in loop) -> exactly three tot_ld pulses, one d pulse after the third, zero chg_p, return to INIT.
- s=200, coins 150 then 100, COIN_UNIT=25 -> d once, then exactly 2 chg_p pulses separated by PULSE_GAP idle cycles, then INIT with tot_clr=1.
- c held high 50 cycles, s=200 -> single tot_ld. c pulsed during busy -> no tot_ld, no change in tot.
- rst_i asserted asynchronously mid-CHANGE (1 pulse of 3 paid) -> chg_p and busy drop without a clock edge; tot_clr=1; no further pulses after release.
- With VENDING_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=100, s=200, one 75 coin, no further coins -> after 100 idle cycles, 3 chg_p pulses, d never high. Without the macro, no pulses after 500 cycles.
